// File: rtl/factorizer_pkg.sv
// factorizer_pkg: shared state enum, factor bit indices (bit0 = divisor 2 ... bit7 = divisor 9) and scan limit
package factorizer_pkg;
  localparam int MAX_N = 127;
  localparam int F2 = 0;
  localparam int F3 = 1;
  localparam int F4 = 2;
  localparam int F5 = 3;
  localparam int F6 = 4;
  localparam int F7 = 5;
  localparam int F8 = 6;
  localparam int F9 = 7;
  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;
endpackage

// File: rtl/residue_counter.sv
// residue_counter: candidate mod K tracker; ports clk, reset_n, load (to 1), inc (wrap at K-1), zero flag
module residue_counter #(
  parameter int K = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic inc,
  output logic zero
);
  logic [3:0] r_res;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_res <= '0;
    else if (load) r_res <= 4'd1;
    else if (inc) r_res <= (r_res == 4'(K - 1)) ? 4'd0 : r_res + 4'd1;
  assign zero = r_res == 4'd0;
endmodule

// File: rtl/factor_finder.sv
// factor_finder: streams every 1..127 whose divisors cover mask; ports start/mask in, busy, num_valid/num_ready/number handshake, done pulse, match_count
module factor_finder
  import factorizer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] mask,
  output logic       busy,
  output logic       num_valid,
  input  logic       num_ready,
  output logic [6:0] number,
  output logic       done,
  output logic [7:0] match_count
);
  state_t r_state;
  logic [7:0] r_mask;
  logic [7:0] r_count;
  logic [6:0] r_c;
  logic [6:0] r_number;
  logic r_valid;
  logic [7:0] w_d;
  logic w_z3, w_z5, w_z7, w_z9, w_load, w_match, w_last, w_xfer, w_inc;
  assign w_load = r_state == IDLE && start;
  assign w_last = r_c == 7'(MAX_N);
  assign w_xfer = r_state == OFFER && num_ready;
  assign w_inc = (r_state == SCAN && !w_match && !w_last) || (w_xfer && !w_last);
  residue_counter #(.K(3)) u_r3 (.clk(clk), .reset_n(reset_n), .load(w_load), .inc(w_inc), .zero(w_z3));
  residue_counter #(.K(5)) u_r5 (.clk(clk), .reset_n(reset_n), .load(w_load), .inc(w_inc), .zero(w_z5));
  residue_counter #(.K(7)) u_r7 (.clk(clk), .reset_n(reset_n), .load(w_load), .inc(w_inc), .zero(w_z7));
  residue_counter #(.K(9)) u_r9 (.clk(clk), .reset_n(reset_n), .load(w_load), .inc(w_inc), .zero(w_z9));
  always_comb begin
    w_d = '0;
    w_d[F2] = !r_c[0];
    w_d[F3] = w_z3;
    w_d[F4] = r_c[1:0] == 2'd0;
    w_d[F5] = w_z5;
    w_d[F6] = !r_c[0] && w_z3;
    w_d[F7] = w_z7;
    w_d[F8] = r_c[2:0] == 3'd0;
    w_d[F9] = w_z9;
  end
  assign w_match = (w_d & r_mask) == r_mask;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_c <= '0;
    else if (w_load) r_c <= 7'd1;
    else if (w_inc) r_c <= r_c + 7'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_mask <= '0;
      r_count <= '0;
      r_number <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (start) begin
            r_state <= SCAN;
            r_mask <= mask;
            r_count <= '0;
          end
        SCAN:
          if (w_match) begin
            r_number <= r_c;
            r_valid <= 1'b1;
            r_state <= OFFER;
          end else if (w_last) r_state <= DONE;
        OFFER:
          if (num_ready) begin
            r_valid <= 1'b0;
            r_count <= r_count + 8'd1;
            r_state <= w_last ? DONE : SCAN;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign num_valid = r_valid;
  assign number = r_number;
  assign match_count = r_count;
endmodule

// File: tb/tb_factor_finder.sv
// tb_factor_finder: randomized-handshake scans of factor_finder checked against a modulo-arithmetic reference list
module tb_factor_finder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] mask = '0;
  logic num_ready = 1'b0;
  logic busy, num_valid, done;
  logic [6:0] number;
  logic [7:0] match_count;
  int total = 0;
  int bad = 0;
  int rmode = 1;
  int done_cnt = 0;
  int exp_q[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [6:0] pn = '0;

  factor_finder dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mask(mask), .busy(busy),
    .num_valid(num_valid), .num_ready(num_ready), .number(number),
    .done(done), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit hit(input int n, input logic [7:0] m);
    for (int k = 2; k <= 9; k++)
      if (m[k-2] && (n % k) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int count_of(input logic [7:0] m);
    int n = 0;
    for (int i = 1; i <= 127; i++) if (hit(i, m)) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    num_ready = rmode == 0 ? 1'b0 : rmode == 1 ? 1'b1 : rmode == 2 ? 1'($urandom_range(0, 1))
              : !(num_valid && number == 7'd64);
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (pv && !pr) begin
        chk("valid_held", int'(num_valid), 1);
        if (num_valid) chk("number_stable", int'(number), int'(pn));
      end
      if (num_valid && num_ready) begin
        if (exp_q.size() == 0) chk("unexpected_number", int'(number), -1);
        else chk("number", int'(number), exp_q.pop_front());
      end
      pv = num_valid;
      pr = num_ready;
      pn = number;
    end
  end

  task automatic load_exp(input logic [7:0] m, output int n);
    n = 0;
    exp_q.delete();
    for (int i = 1; i <= 127; i++) if (hit(i, m)) begin
      exp_q.push_back(i);
      n++;
    end
  endtask

  task automatic run(input logic [7:0] m, input int rm, input bit poke, input string tag);
    int n;
    int cyc = 0;
    bit got = 1'b0;
    load_exp(m, n);
    rmode = rm;
    @(posedge clk); #1;
    mask = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got && cyc < 2000) begin
      cyc++;
      @(negedge clk);
      if (poke && cyc == 20) begin
        start = 1'b1;
        mask = ~m;
      end
      if (poke && cyc == 25) begin
        start = 1'b0;
        mask = m;
      end
      if (done) got = 1'b1;
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_match_count"}, int'(match_count), n);
    chk({tag, "_leftover"}, exp_q.size(), 0);
    if (rm == 1) chk({tag, "_done_cycle"}, cyc, 128 + n);
    if (poke) begin
      start = 1'b1;
      mask = ~m;
    end
    @(posedge clk); #1;
    start = 1'b0;
    mask = m;
    @(negedge clk);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_count_hold"}, int'(match_count), n);
  endtask

  initial begin
    int n;
    int saved;
    bit found = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(num_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_number", int'(number), 0);
    chk("rst_count", int'(match_count), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("model_80", count_of(8'h80), 14);
    chk("model_24", count_of(8'h24), 4);
    chk("model_21", count_of(8'h21), 9);
    chk("model_ff", count_of(8'hFF), 0);
    chk("model_00", count_of(8'h00), 127);
    chk("model_56_24", int'(hit(56, 8'h24)), 1);
    chk("model_42_24", int'(hit(42, 8'h24)), 0);
    run(8'h80, 1, 1'b0, "m80");
    run(8'h24, 1, 1'b0, "m24");
    run(8'h21, 1, 1'b1, "m21_poke");
    run(8'hFF, 1, 1'b0, "mff");
    run(8'h00, 2, 1'b0, "m00_rand");
    run(8'h80, 2, 1'b1, "m80_rand_poke");
    run(8'($urandom_range(0, 255)) & 8'h0B, 2, 1'b0, "mrand");
    load_exp(8'h01, n);
    rmode = 3;
    @(posedge clk); #1;
    mask = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (num_valid && number == 7'd64) found = 1'b1;
    end
    chk("rst_reach_64", int'(found), 1);
    @(negedge clk);
    saved = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", int'(num_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(match_count), 0);
    exp_q.delete();
    @(negedge clk); #2;
    reset_n = 1'b1;
    chk("abort_no_done", done_cnt, saved);
    run(8'h01, 1, 1'b0, "m01_restart");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/factor_finder.md
# factor_finder

Inverse companion to `factorizer`: instead of mapping a number to its divisor mask, it takes a required divisor mask and streams every number in 1..127 whose divisibility by 2..9 covers that mask. It scans candidates in ascending order and presents each match on a valid/ready output. On completion it pulses `done` and reports the match count. It sits downstream of the command logic that currently drives `factorizer`, sharing its 8-bit factor-mask encoding.

## Interface
Parameters:
- `MAX_N`, 127: last candidate scanned; fixed to the 7-bit number range.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `mask` in 8: required divisors, same encoding as `factorizer.factors` (bit0 = 2, bit1 = 3, ..., bit7 = 9); latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE cycle.
- `num_valid` out 1: `number` holds a match.
- `num_ready` in 1: consumer accepts `number` when `num_valid` is also high.
- `number` out 7: matching candidate.
- `done` out 1: one-cycle pulse at end of scan.
- `match_count` out 8: matches accepted in the current or last scan.

## Operation
- States: IDLE, SCAN, OFFER, DONE.
- IDLE, `start` = 1:
  - latch `mask`;
  - set candidate `c` = 1 and residues r3 = r5 = r7 = r9 = 1;
  - clear `match_count`;
  - go to SCAN.
- `start` is ignored in every other state, and `mask` changes after latching are ignored.
- Divisibility of `c` uses no divider:
  - d2 = !c[0], d4 = c[1:0] == 0, d8 = c[2:0] == 0;
  - d3, d5, d7, d9 = (r3, r5, r7, r9) == 0;
  - d6 = d2 & d3.
- Candidate divisor mask D = {d9, d8, d7, d6, d5, d4, d3, d2}. The candidate matches when (D & latched_mask) == latched_mask.
- Each residue advances with `c`: rk <= (rk == k-1) ? 0 : rk + 1.
- SCAN, one candidate per cycle:
  - match: `number` <= c, `num_valid` <= 1, go to OFFER;
  - no match, c == MAX_N: go to DONE;
  - no match otherwise: c and residues advance, stay in SCAN.
- OFFER: hold `number` and `num_valid` stable until `num_ready`. On the transfer:
  - `num_valid` <= 0, `match_count` += 1;
  - `number` == MAX_N: go to DONE;
  - otherwise: c and residues advance, go to SCAN.
- DONE: `done` = 1 for exactly one cycle, then IDLE. `match_count` holds until the next accepted `start`.
- `mask` = 0 matches all 127 candidates; the 8-bit `match_count` never overflows (maximum 127).

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE;
  - `busy`, `num_valid`, `done` = 0;
  - `number`, `match_count`, `c`, residues = 0.
- `reset_n` low mid-scan aborts the scan: `num_valid` drops immediately, no `done` pulse.
- All outputs are registered or decoded directly from the state register. `done` = (state == DONE) and `busy` = (state != IDLE).
- `start` accepted at edge 0: SCAN evaluates c = 1 in cycle 1.
- A match on candidate k raises `num_valid` on the edge ending k's SCAN cycle.
- Non-matching candidates cost 1 cycle each. A match costs 1 SCAN cycle plus at least 1 OFFER cycle (1 + number of stall cycles).
- Scan with no matches: SCAN cycles 1..127, `done` high in cycle 128, IDLE in cycle 129.
- `num_ready` high while `num_valid` is low has no effect. `num_valid` never drops without a transfer, except on reset.
- `start` high in the DONE cycle is ignored; `start` is accepted in the first IDLE cycle.

## Structure
- Shared package `factorizer_pkg`:
  - state enum {IDLE, SCAN, OFFER, DONE};
  - factor bit-index constants (F2 = 0 ... F9 = 7);
  - `MAX_N`.
- `factorizer` also adopts the factor bit-index constants.
- One sub-module, `residue_counter`:
  - parameter K, 4-bit residue;
  - `load` to 1, `inc` with wrap at K-1;
  - `zero` flag output;
  - instantiated four times (K = 3, 5, 7, 9).

## Test plan
- `mask` = 0x80 (9), `num_ready` tied 1 -> numbers 9, 18, ..., 126 (14 transfers), `match_count` = 14, then `done` pulse.
- `mask` = 0x24 (4 and 7) -> 28, 56, 84, 112; `match_count` = 4. `mask` = 0x21 (2 and 7) -> 14, 28, ..., 126, 9 transfers.
- `mask` = 0xFF (lcm 2520) -> no `num_valid`; `done` in cycle 128 after `start`; `match_count` = 0.
- `mask` = 0x00 with `num_ready` random 50% -> 1..127 in order, `number` stable while stalled, `match_count` = 127, no duplicates or gaps.
- `mask` = 0x01, reset pulsed while OFFER holds 64 -> `num_valid` and `busy` drop immediately, no `done`. A new `start` restarts from 2.
- `start` reasserted during SCAN and during DONE, with `mask` toggled -> ignored; results follow the originally latched mask.
